oled_text_writer: RTL and testbench
===================================

Name: oled_text_writer

Overview:
Upstream feeder for oledDriver. Accepts a byte stream (ASCII) over a valid/ready handshake and tracks a 4x16 text cursor. For each byte it issues single-cycle showchar or clear commands to the driver, sequenced against the driver's ready signal. It interprets a small set of control codes, so firmware/UART logic can print text without managing display positions.

Parameters:
ACK_TIMEOUT, 16, cycles to wait for drv_ready to fall after a command pulse before declaring the command lost.
ROWS, 4, text rows (fixed by the display; cursor_row width stays 2).
COLS, 16, text columns (fixed; cursor_col width stays 4).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input byte valid
in_data  in  8  input byte
in_ready  out  1  writer can accept a byte this cycle
drv_ready  in  1  oledDriver ready
showchar  out  1  one-cycle command pulse to the driver
clear  out  1  one-cycle command pulse to the driver
charval  out  8  character to the driver
char_row  out  2  row to the driver
char_col  out  4  column to the driver
cursor_row  out  2  current cursor row
cursor_col  out  4  current cursor column
busy  out  1  high whenever state != IDLE
err  out  1  sticky flag: an ACK_TIMEOUT expired; cleared only by reset

Behaviour:
- Reset (async, immediate, also mid-operation):
  - state=IDLE.
  - All outputs 0: showchar, clear, charval, char_row, char_col, cursor_row, cursor_col, err, busy.
  - in_ready=0 while rst_n is low; in_ready=1 from the first cycle after reset is released.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE. All outputs are registered except in_ready=(state==IDLE) and busy=(state!=IDLE).
- IDLE: a byte is accepted on a clock edge where in_valid && in_ready. Byte classification:
  - 0x20..0x7E printable:
    - Latch charval=byte, char_row=cursor_row, char_col=cursor_col; pend_cmd=CHAR.
    - Go to ISSUE.
  - 0x0C form feed: pend_cmd=CLR; go to ISSUE.
  - 0x0A LF: cursor_col=0; cursor_row=cursor_row+1 (3 wraps to 0); stay IDLE. Zero-cycle stall: next byte can be accepted the following cycle.
  - 0x0D CR: cursor_col=0; stay IDLE.
  - 0x08 BS: cursor_col=cursor_col-1, saturating at 0; the row is unchanged; stay IDLE.
  - Any other byte (0x00..0x1F not listed above, 0x7F..0xFF): consumed and ignored; cursor unchanged.
- ISSUE:
  - Waits, with no timeout, until drv_ready=1.
  - In that cycle it registers showchar=1 (CHAR) or clear=1 (CLR) for exactly one cycle, then goes to WAIT_ACK.
- WAIT_ACK:
  - Counts cycles while drv_ready=1.
  - drv_ready=0 → WAIT_DONE.
  - Count reaches ACK_TIMEOUT → set err=1, apply the completion action, go to IDLE.
- WAIT_DONE: drv_ready=1 → apply the completion action, go to IDLE. There is no timeout, because the driver's bitmap/clear operations are long.
- Completion action:
  - CHAR: cursor_col+1. Column 15 wraps to 0 and increments the row; row 3 wraps to 0.
  - CLR: cursor_row=0, cursor_col=0.
- Stability: charval/char_row/char_col stay stable from ISSUE until the next byte is latched.
- Latency: byte accepted at edge N → command pulse visible after edge N+1 if drv_ready=1. Minimum 4 cycles per printable byte.
- The writer never issues showbmp; that driver input is tied 0 at the top level.
- Simultaneous events: in_valid is ignored outside IDLE (in_ready=0). The command pulse and the timeout count never overlap.

Decomposition:
- Package oled_text_pkg holds:
  - state enum (IDLE/ISSUE/WAIT_ACK/WAIT_DONE) and pend_cmd enum (CHAR/CLR);
  - control-code constants CH_LF=8'h0A, CH_CR=8'h0D, CH_FF=8'h0C, CH_BS=8'h08;
  - ROWS/COLS localparams.
- No sub-module. Cursor arithmetic stays inline as a small function in the package (cursor_advance).

Test Plan:
1. Reset, drv_ready=1 with a driver model that drops ready 2 cycles after a pulse and raises it 10 later; send 'A' (0x41) → one showchar pulse with charval=0x41, row=0, col=0; afterwards cursor=(0,1), err=0.
2. Send 17 printable bytes → the 16th goes to (0,15) and the 17th to (1,0); cursor ends at (1,1). Continue to 64 characters total → cursor wraps to (0,0).
3. At cursor (2,5): send LF → (3,0) with no pulse and in_ready back high next cycle. LF at row 3 → (0,0). CR → col 0. BS at col 0 → stays 0.
4. Send 0x0C with the driver holding ready low 5 cycles before the pulse → clear pulses exactly once after ready rises; cursor=(0,0); showchar never asserts.
5. Driver model never drops ready, ACK_TIMEOUT=16; send 'Z' → err=1 exactly 16 cycles after the pulse, cursor advances, in_ready returns high. err persists through later bytes.
6. Assert rst_n low while in WAIT_DONE → all outputs 0 asynchronously. After release, in_ready=1, and bytes 0x00 and 0xFF are consumed with no pulse and no cursor change.

Source files
------------

// File: rtl/oled_text_pkg.sv
// Shared types, constants and cursor arithmetic for the OLED text writer.
// The display is a fixed 4x16 character grid.
package oled_text_pkg;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 16;
  localparam int unsigned ROW_W = 2;
  localparam int unsigned COL_W = 4;

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  typedef enum logic {
    CHAR,
    CLR
  } pend_cmd_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } cursor_t;

  function automatic logic [ROW_W-1:0] row_next(input logic [ROW_W-1:0] row);
    return (row == ROW_W'(ROWS - 1)) ? '0 : row + ROW_W'(1);
  endfunction

  // Step one cell right, wrapping to the next row and from the last row to the top.
  function automatic cursor_t cursor_advance(input cursor_t cur);
    cursor_t nxt;
    nxt = cur;
    if (cur.col == COL_W'(COLS - 1)) begin
      nxt.col = '0;
      nxt.row = row_next(cur.row);
    end else begin
      nxt.col = cur.col + COL_W'(1);
    end
    return nxt;
  endfunction

  // Cursor update once the driver has finished (or lost) a command.
  function automatic cursor_t cursor_complete(input pend_cmd_t cmd, input cursor_t cur);
    cursor_t nxt;
    nxt = '0;
    if (cmd == CHAR) begin
      nxt = cursor_advance(cur);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/oled_text_writer.sv
// Byte-stream front end for the OLED driver: tracks a text cursor, interprets
// a few control codes and issues showchar/clear pulses paced by drv_ready.
module oled_text_writer
  import oled_text_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             drv_ready,
  output logic             showchar,
  output logic             clear,
  output logic [7:0]       charval,
  output logic [ROW_W-1:0] char_row,
  output logic [COL_W-1:0] char_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic [COL_W-1:0] cursor_col,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t           state, state_d;
  pend_cmd_t        pend_cmd, pend_cmd_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  cursor_t          cur, cur_d;
  cursor_t          pos, pos_d;
  logic [7:0]       charval_d;
  logic             showchar_d, clear_d, err_d;
  logic             printable;

  assign in_ready   = rst_n && (state == IDLE);
  assign busy       = (state != IDLE);
  assign cursor_row = cur.row;
  assign cursor_col = cur.col;
  assign char_row   = pos.row;
  assign char_col   = pos.col;
  assign printable  = (in_data >= 8'h20) && (in_data <= 8'h7E);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend_cmd <= CHAR;
      cnt      <= '0;
      cur      <= '0;
      pos      <= '0;
      charval  <= '0;
      showchar <= 1'b0;
      clear    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      pend_cmd <= pend_cmd_d;
      cnt      <= cnt_d;
      cur      <= cur_d;
      pos      <= pos_d;
      charval  <= charval_d;
      showchar <= showchar_d;
      clear    <= clear_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    pend_cmd_d = pend_cmd;
    cnt_d      = cnt;
    cur_d      = cur;
    pos_d      = pos;
    charval_d  = charval;
    showchar_d = 1'b0;
    clear_d    = 1'b0;
    err_d      = err;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          if (printable) begin
            charval_d  = in_data;
            pos_d      = cur;
            pend_cmd_d = CHAR;
            state_d    = ISSUE;
          end else begin
            // Control codes other than form feed only move the cursor.
            case (in_data)
              CH_FF: begin
                pend_cmd_d = CLR;
                state_d    = ISSUE;
              end
              CH_LF: begin
                cur_d.col = '0;
                cur_d.row = row_next(cur.row);
              end
              CH_CR: cur_d.col = '0;
              CH_BS: begin
                if (cur.col != '0) begin
                  cur_d.col = cur.col - COL_W'(1);
                end
              end
              default: ;
            endcase
          end
        end
      end

      ISSUE: begin
        if (drv_ready) begin
          showchar_d = (pend_cmd == CHAR);
          clear_d    = (pend_cmd == CLR);
          cnt_d      = '0;
          state_d    = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
        // The driver should drop ready to acknowledge; give up after ACK_TIMEOUT cycles.
        if (!drv_ready) begin
          state_d = WAIT_DONE;
        end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          cur_d   = cursor_complete(pend_cmd, cur);
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      WAIT_DONE: begin
        if (drv_ready) begin
          cur_d   = cursor_complete(pend_cmd, cur);
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_oled_text_writer.sv
// Self-checking bench for oled_text_writer with a simple OLED driver model
// and a scoreboard of expected command pulses.
module tb_oled_text_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       drv_ready;
  logic       showchar, clear;
  logic [7:0] charval;
  logic [1:0] char_row, cursor_row;
  logic [3:0] char_col, cursor_col;
  logic       busy, err;

  oled_text_writer #(.ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .drv_ready(drv_ready), .showchar(showchar),
    .clear(clear), .charval(charval), .char_row(char_row), .char_col(char_col),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Driver model: ready drops 2 cycles after a pulse and returns 10 cycles later.
  int   cycle = 0;
  int   age = 0;
  int   hold_until = 0;
  logic drv_never = 1'b0;

  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (showchar || clear) age <= 1;
    else if (age >= 12) age <= 0;
    else if (age != 0) age <= age + 1;
  end

  assign drv_ready = (cycle >= hold_until) && (drv_never || age < 2 || age > 11);

  typedef struct {
    logic       is_clr;
    logic [7:0] ch;
    logic [1:0] row;
    logic [3:0] col;
  } pulse_t;

  typedef struct {
    logic [7:0] b;
    int         pulses;
    logic [1:0] row;
    logic [3:0] col;
  } vec_t;

  localparam int NV = 23;

  pulse_t     sbq[$];
  vec_t       vecs[NV];
  int         tests = 0, fails = 0;
  int         n_pulse = 0, n_show = 0, n_clr = 0, last_pulse_cycle = 0;
  logic [1:0] m_row = 2'd0;
  logic [3:0] m_col = 4'd0;
  int         p0, s0, c0, pc, n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // Advance to the next falling edge and score any command pulse seen there.
  task automatic tick();
    pulse_t e;
    @(negedge clk);
    if (showchar || clear) begin
      n_pulse++;
      last_pulse_cycle = cycle;
      if (showchar) n_show++;
      if (clear) n_clr++;
      check("pulse_onehot", 32'(showchar & clear), 32'd0);
      if (sbq.size() == 0) begin
        fail_now("unexpected_pulse");
      end else begin
        e = sbq.pop_front();
        check("pulse_kind", 32'(clear), 32'(e.is_clr));
        if (!e.is_clr) begin
          check("charval", 32'(charval), 32'(e.ch));
          check("char_row", 32'(char_row), 32'(e.row));
          check("char_col", 32'(char_col), 32'(e.col));
        end
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    pulse_t e;
    if (b >= 8'h20 && b <= 8'h7E) begin
      e.is_clr = 1'b0; e.ch = b; e.row = m_row; e.col = m_col;
      sbq.push_back(e);
      if (m_col == 4'd15) begin
        m_col = 4'd0;
        m_row = m_row + 2'd1;
      end else begin
        m_col = m_col + 4'd1;
      end
    end else if (b == 8'h0C) begin
      e.is_clr = 1'b1; e.ch = 8'h00; e.row = 2'd0; e.col = 4'd0;
      sbq.push_back(e);
      m_row = 2'd0;
      m_col = 4'd0;
    end else if (b == 8'h0A) begin
      m_col = 4'd0;
      m_row = m_row + 2'd1;
    end else if (b == 8'h0D) begin
      m_col = 4'd0;
    end else if (b == 8'h08) begin
      if (m_col != 4'd0) m_col = m_col - 4'd1;
    end
  endtask

  // Offer one byte; returns at the falling edge after it was accepted.
  task automatic send(input logic [7:0] b);
    int k = 0;
    while (!in_ready && k < 200) begin
      tick();
      k++;
    end
    if (!in_ready) begin
      fail_now("in_ready_wait");
      return;
    end
    in_valid = 1'b1;
    in_data  = b;
    model_byte(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || sbq.size() != 0) && k < 200) begin
      tick();
      k++;
    end
    if (busy || sbq.size() != 0) fail_now("wait_idle");
  endtask

  task automatic check_cursor(input string name, input logic [1:0] r, input logic [3:0] c);
    check({name, "_row"}, 32'(cursor_row), 32'(r));
    check({name, "_col"}, 32'(cursor_col), 32'(c));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{8'h0A, 0, 2'd3, 4'd0};
    vecs[1]  = '{8'h0A, 0, 2'd0, 4'd0};
    vecs[2]  = '{8'h61, 1, 2'd0, 4'd1};
    vecs[3]  = '{8'h62, 1, 2'd0, 4'd2};
    vecs[4]  = '{8'h63, 1, 2'd0, 4'd3};
    vecs[5]  = '{8'h0D, 0, 2'd0, 4'd0};
    vecs[6]  = '{8'h08, 0, 2'd0, 4'd0};
    vecs[7]  = '{8'h71, 1, 2'd0, 4'd1};
    vecs[8]  = '{8'h08, 0, 2'd0, 4'd0};
    vecs[9]  = '{8'h00, 0, 2'd0, 4'd0};
    vecs[10] = '{8'hFF, 0, 2'd0, 4'd0};
    vecs[11] = '{8'h7F, 0, 2'd0, 4'd0};
    vecs[12] = '{8'h1B, 0, 2'd0, 4'd0};
    vecs[13] = '{8'h7E, 1, 2'd0, 4'd1};
    vecs[14] = '{8'h20, 1, 2'd0, 4'd2};
    vecs[15] = '{8'h0A, 0, 2'd1, 4'd0};
    vecs[16] = '{8'h09, 0, 2'd1, 4'd0};
    vecs[17] = '{8'h30, 1, 2'd1, 4'd1};
    vecs[18] = '{8'h1F, 0, 2'd1, 4'd1};
    vecs[19] = '{8'h08, 0, 2'd1, 4'd0};
    vecs[20] = '{8'h35, 1, 2'd1, 4'd1};
    vecs[21] = '{8'h36, 1, 2'd1, 4'd2};
    vecs[22] = '{8'h08, 0, 2'd1, 4'd1};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check_cursor("rst_cursor", 2'd0, 4'd0);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Single character and pulse latency
    send(8'h41);
    check("latency_no_pulse_yet", 32'(showchar), 32'd0);
    s0 = n_show;
    tick();
    check("latency_pulse", 32'(n_show), 32'(s0 + 1));
    wait_idle();
    check_cursor("after_A", 2'd0, 4'd1);
    check("err_after_A", 32'(err), 32'd0);

    // Home, then 64 characters with row and screen wrap
    send(8'h0C);
    wait_idle();
    check_cursor("after_ff", 2'd0, 4'd0);
    for (int i = 0; i < 64; i++) begin
      send(8'h21 + 8'(i));
      wait_idle();
      if (i == 16) check_cursor("after_17", 2'd1, 4'd1);
    end
    check_cursor("after_64", 2'd0, 4'd0);

    // Move to (2,5) and apply the control-code table
    for (int i = 0; i < 37; i++) begin
      send(8'h41 + 8'(i % 26));
      wait_idle();
    end
    check_cursor("at_2_5", 2'd2, 4'd5);
    for (int i = 0; i < NV; i++) begin
      p0 = n_pulse;
      send(vecs[i].b);
      if (vecs[i].pulses == 0) begin
        check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
        check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      end
      wait_idle();
      check($sformatf("vec%0d_pulses", i), 32'(n_pulse - p0), 32'(vecs[i].pulses));
      check_cursor($sformatf("vec%0d", i), vecs[i].row, vecs[i].col);
    end

    // Form feed while the driver holds ready low
    s0 = n_show;
    c0 = n_clr;
    hold_until = cycle + 5;
    send(8'h0C);
    wait_idle();
    check("ff_clear_once", 32'(n_clr), 32'(c0 + 1));
    check("ff_no_showchar", 32'(n_show), 32'(s0));
    check("ff_pulse_cycle", 32'(last_pulse_cycle), 32'(hold_until + 1));
    check_cursor("ff_hold", 2'd0, 4'd0);

    // Lost acknowledge: err exactly ACK_TIMEOUT cycles after the pulse
    drv_never = 1'b1;
    p0 = n_pulse;
    send(8'h5A);
    n = 0;
    while (n_pulse == p0 && n < 10) begin tick(); n++; end
    if (n_pulse == p0) fail_now("timeout_pulse");
    pc = last_pulse_cycle;
    check("err_before_timeout", 32'(err), 32'd0);
    n = 0;
    while (!err && n < 40) begin tick(); n++; end
    if (!err) fail_now("timeout_err");
    else check("err_delay", 32'(cycle - pc), 32'd16);
    check("timeout_in_ready", 32'(in_ready), 32'd1);
    check_cursor("timeout", 2'd0, 4'd1);
    drv_never = 1'b0;
    send(8'h59);
    wait_idle();
    check("err_sticky", 32'(err), 32'd1);
    check_cursor("after_Y", 2'd0, 4'd2);

    // Asynchronous reset while waiting for the driver to finish
    send(8'h4B);
    n = 0;
    while (drv_ready && n < 20) begin tick(); n++; end
    if (drv_ready) fail_now("drv_drop");
    tick();
    tick();
    check("wait_done_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_showchar", 32'(showchar), 32'd0);
    check("arst_clear", 32'(clear), 32'd0);
    check("arst_charval", 32'(charval), 32'd0);
    check("arst_char_row", 32'(char_row), 32'd0);
    check("arst_char_col", 32'(char_col), 32'd0);
    check_cursor("arst_cursor", 2'd0, 4'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    m_row = 2'd0;
    m_col = 4'd0;
    tick();
    rst_n = 1'b1;
    tick();
    check("in_ready_after_arst", 32'(in_ready), 32'd1);
    p0 = n_pulse;
    send(8'h00);
    send(8'hFF);
    wait_idle();
    check("ignored_no_pulse", 32'(n_pulse - p0), 32'd0);
    check_cursor("ignored", 2'd0, 4'd0);
    check("ignored_err", 32'(err), 32'd0);
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
